mw_stage: RTL and testbench
===========================

Name: mw_stage

Overview:
- Writeback stage directly downstream of the execute/writeback pipeline register. It consumes that register's outputs (op, ot, wreg, result, pc).
- It performs the data-memory access for loads and stores over a req/ack handshake and drives the register-file write port.
- It stalls the upstream pipeline while a memory access is outstanding and keeps a retired-instruction count plus a sticky memory-timeout error flag.

Parameters:
- TIMEOUT, 255, cycles in MEM_REQ without dmem_ack before the access is abandoned (1..65535)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pc_in  in  32  pc of instruction in writeback (debug only)
- op_in  in  6  opcode; 6'd55 is a bubble
- ot_in  in  32  second operand; store data
- wreg_in  in  5  destination register; 0 means no write
- result_in  in  32  ALU result; effective address for loads/stores
- stall  out  1  freezes all upstream pipeline registers, including the EW register, while 1
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- dmem_req  out  1  memory request, held until ack or timeout
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  32  word address; valid while dmem_req
- dmem_wdata  out  32  store data; valid while dmem_req
- dmem_ack  in  1  access complete; may arrive in the first dmem_req cycle
- dmem_rdata  in  32  load data; valid in the ack cycle
- err  out  1  sticky timeout flag
- retired  out  CNT_W  count of completed non-bubble instructions
- cur_pc  out  32  pc of the instruction being completed (debug)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE; dmem_req=0, err=0, retired=0, timer=0 at the next edge.
  - This applies mid-access: the request is dropped and the pending load is never written.
  - While rst is high, stall=0 and rf_we=0.
- States and outputs:
  - IDLE: inputs are decoded combinationally.
    - Bubble (op_in=55): rf_we=0, stall=0, no count.
    - ALU or other op: rf_we = (wreg_in!=0), rf_waddr=wreg_in, rf_wdata=result_in, stall=0. retired increments at the edge. Latency is 0 cycles.
    - OP_LW or OP_SW: stall=1 and rf_we=0. The block latches op, wreg, result, ot and pc, and goes to MEM_REQ.
  - MEM_REQ:
    - Outputs: dmem_req=1, dmem_we=(op==OP_SW), dmem_addr=latched result, dmem_wdata=latched ot, stall=1.
    - Each cycle without ack, the timer increments.
    - On dmem_ack: capture dmem_rdata, go to FIN.
    - If timer reaches TIMEOUT-1 without ack: set err, load data=32'h0, go to FIN.
    - If ack and timeout occur in the same cycle, ack wins and err is not set.
  - FIN:
    - Outputs: dmem_req=0, stall=0.
    - Load: rf_we=(latched wreg!=0), rf_waddr=latched wreg, rf_wdata=captured data.
    - Store: rf_we=0.
    - retired increments; timer clears; go to IDLE.
- Minimum load/store occupancy is 3 cycles (IDLE, MEM_REQ with immediate ack, FIN). The next instruction is consumed in the cycle after FIN.
- dmem_ack outside MEM_REQ is ignored.
- A load to r0 performs the memory access but never asserts rf_we.
- retired wraps modulo 2^CNT_W. err clears only on rst.
- cur_pc: pc_in in IDLE, latched pc otherwise.
- While stall=1, input values are don't-care; only latched copies are used.

Decomposition:
- Shared package pipe_pkg holds:
  - OP_NOP=6'd55, OP_LW=6'd16, OP_SW=6'd24
  - state encoding IDLE/MEM_REQ/FIN
- The EW register reset value must equal OP_NOP, taken from the package.
- No sub-module: a single FSM plus timer and counter.

Test Plan:
- ALU op=6'd0, wreg=5, result=32'h1234 in IDLE -> same cycle rf_we=1, waddr=5, wdata=32'h1234, stall=0; retired=1 next cycle.
- LW result=32'h40, ack in first MEM_REQ cycle with rdata=32'hCAFEF00D, wreg=7 -> stall high for 2 cycles; FIN cycle rf_we=1, waddr=7, wdata=32'hCAFEF00D; dmem_we=0.
- SW result=32'h80, ot=32'h55AA, ack after 4 cycles -> dmem_req held 5 cycles with addr=32'h80, wdata=32'h55AA, we=1; no rf_we; retired+1.
- LW with no ack, TIMEOUT=8 -> req drops after 8 MEM_REQ cycles; err=1 and stays 1; FIN writes 32'h0; ack and timeout in the same cycle -> err stays 0.
- Bubble op=55 with wreg=3 -> rf_we=0, retired unchanged; LW to wreg=0 -> access occurs, rf_we never 1.
- rst asserted in the second MEM_REQ cycle -> next edge req=0, state IDLE, err=0, retired=0, no rf_we; retired at all-ones -> next completion gives 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes seen in writeback and the writeback FSM state encoding.
package pipe_pkg;

    localparam logic [5:0] OP_NOP = 6'd55;
    localparam logic [5:0] OP_LW  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd24;

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        FIN     = 2'd2
    } mw_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mw_stage_if.sv
// Data-memory req/ack channel between the writeback stage (master) and memory (slave).
interface mw_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mw_stage.sv
// Writeback stage: retires ALU ops in place, runs loads/stores over the dmem handshake,
// stalls upstream while an access is outstanding, counts retirements, flags timeouts.
module mw_stage
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    input  logic [5:0]       op_in,
    input  logic [31:0]      ot_in,
    input  logic [4:0]       wreg_in,
    input  logic [31:0]      result_in,
    output logic             stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    mw_stage_if.master       dmem,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [31:0]      cur_pc
);

    mw_state_e          state_q, state_d;
    logic [5:0]         op_q;
    logic [4:0]         wreg_q;
    logic [31:0]        result_q;
    logic [31:0]        ot_q;
    logic [31:0]        pc_q;
    logic [31:0]        data_q;
    logic [TIMER_W-1:0] timer_q;

    logic latch;
    logic capture;
    logic set_err;
    logic retire;
    logic timeout_hit;

    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT - 1));

    // Next state and decode; IDLE outputs follow the inputs with zero latency.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = wreg_in;
        rf_wdata   = result_in;
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = result_q;
        dmem.wdata = ot_q;
        cur_pc     = pc_q;
        latch      = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            IDLE: begin
                cur_pc = pc_in;
                if (op_in == OP_NOP) begin
                    state_d = IDLE;
                end else if (is_mem_op(op_in)) begin
                    stall   = 1'b1;
                    latch   = 1'b1;
                    state_d = MEM_REQ;
                end else begin
                    rf_we  = (wreg_in != 5'd0);
                    retire = 1'b1;
                end
            end
            MEM_REQ: begin
                dmem.req = 1'b1;
                dmem.we  = (op_q == OP_SW);
                stall    = 1'b1;
                // Ack takes priority over a coincident timeout.
                if (dmem.ack) begin
                    capture = 1'b1;
                    state_d = FIN;
                end else if (timeout_hit) begin
                    capture = 1'b1;
                    set_err = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                rf_waddr = wreg_q;
                rf_wdata = data_q;
                rf_we    = (op_q == OP_LW) && (wreg_q != 5'd0);
                retire   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            stall = 1'b0;
            rf_we = 1'b0;
        end
    end

    // State, latched instruction, timer, error flag and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            wreg_q   <= 5'd0;
            result_q <= 32'd0;
            ot_q     <= 32'd0;
            pc_q     <= 32'd0;
            data_q   <= 32'd0;
            timer_q  <= '0;
            err      <= 1'b0;
            retired  <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q     <= op_in;
                wreg_q   <= wreg_in;
                result_q <= result_in;
                ot_q     <= ot_in;
                pc_q     <= pc_in;
                timer_q  <= '0;
            end
            if (state_q == MEM_REQ && !dmem.ack) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
            if (state_q == FIN) begin
                timer_q <= '0;
            end
            if (capture) begin
                data_q <= dmem.ack ? dmem.rdata : 32'h0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mw_stage.sv
// Directed bench for mw_stage: vector table for single-cycle ops, hand sequences for memory ops.
module tb_mw_stage;
    import pipe_pkg::*;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_in;
    logic [5:0]    op_in;
    logic [31:0]   ot_in;
    logic [4:0]    wreg_in;
    logic [31:0]   result_in;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          err;
    logic [CW-1:0] retired;
    logic [31:0]   cur_pc;

    mw_stage_if dmem ();

    mw_stage #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .op_in(op_in), .ot_in(ot_in),
        .wreg_in(wreg_in), .result_in(result_in), .stall(stall), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dmem(dmem), .err(err),
        .retired(retired), .cur_pc(cur_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  wreg;
        logic [31:0] res;
        logic [31:0] pc;
        logic        we;
        logic        cnt;
    } vec_t;

    vec_t        vecs [6];
    int          checks   = 0;
    int          failures = 0;
    logic [CW-1:0] exp_ret = '0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        op_in = OP_NOP; wreg_in = 5'd0; result_in = 32'd0; ot_in = 32'd0; pc_in = 32'd0;
    endtask

    // One load/store from the IDLE decode cycle through FIN; ack_at=0 means never ack.
    task automatic mem_op(input logic [5:0] op, input logic [4:0] wreg, input logic [31:0] addr,
                          input logic [31:0] ot, input logic [31:0] pc, input int ack_at,
                          input logic [31:0] rdata, input int exp_req, input logic exp_e,
                          input logic exp_wr, input logic [31:0] exp_data);
        int n;
        n = 0;
        op_in = op; wreg_in = wreg; result_in = addr; ot_in = ot; pc_in = pc;
        mid();
        check("mem_idle_stall", 32'(stall), 32'd1);
        check("mem_idle_rf_we", 32'(rf_we), 32'd0);
        check("mem_idle_req", 32'(dmem.req), 32'd0);
        tick();
        op_in = 6'd0; wreg_in = 5'd9; result_in = 32'hDEAD; ot_in = 32'hBEEF; pc_in = 32'h999;
        for (int k = 1; k <= int'(TO) + 2; k++) begin
            dmem.ack   = (k == ack_at);
            dmem.rdata = (k == ack_at) ? rdata : 32'hBAD0BAD0;
            mid();
            if (!dmem.req) break;
            n++;
            check("req_stall", 32'(stall), 32'd1);
            check("req_rf_we", 32'(rf_we), 32'd0);
            check("req_we", 32'(dmem.we), 32'((op == OP_SW)));
            check("req_addr", dmem.addr, addr);
            check("req_wdata", dmem.wdata, ot);
            check("req_cur_pc", cur_pc, pc);
            tick();
        end
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        check("req_cycles", 32'(n), 32'(exp_req));
        check("fin_stall", 32'(stall), 32'd0);
        check("fin_rf_we", 32'(rf_we), 32'(exp_wr));
        if (exp_wr) begin
            check("fin_waddr", 32'(rf_waddr), 32'(wreg));
            check("fin_wdata", rf_wdata, exp_data);
        end
        tick();
        exp_ret = exp_ret + CW'(1);
        exp_err = exp_err | exp_e;
        check("mem_retired", 32'(retired), 32'(exp_ret));
        check("mem_err", 32'(err), 32'(exp_err));
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{op: 6'd0,  wreg: 5'd5,  res: 32'h1234,     pc: 32'h100, we: 1'b1, cnt: 1'b1};
        vecs[1] = '{op: OP_NOP, wreg: 5'd3, res: 32'h777,      pc: 32'h104, we: 1'b0, cnt: 1'b0};
        vecs[2] = '{op: 6'd3,  wreg: 5'd0,  res: 32'hABC,      pc: 32'h108, we: 1'b0, cnt: 1'b1};
        vecs[3] = '{op: 6'd1,  wreg: 5'd31, res: 32'hFFFFFFFF, pc: 32'h10C, we: 1'b1, cnt: 1'b1};
        vecs[4] = '{op: 6'd17, wreg: 5'd2,  res: 32'h5555,     pc: 32'h110, we: 1'b1, cnt: 1'b1};
        vecs[5] = '{op: 6'd23, wreg: 5'd4,  res: 32'h0,        pc: 32'h114, we: 1'b1, cnt: 1'b1};

        dmem.ack = 1'b0; dmem.rdata = 32'h0;
        rst = 1'b1;
        op_in = OP_LW; wreg_in = 5'd1; result_in = 32'h4; ot_in = 32'h0; pc_in = 32'h0;
        tick();
        tick();
        mid();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        mid();
        check("rst_req", 32'(dmem.req), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);
        tick();

        foreach (vecs[i]) begin
            op_in = vecs[i].op; wreg_in = vecs[i].wreg; result_in = vecs[i].res; pc_in = vecs[i].pc;
            mid();
            check("vec_rf_we", 32'(rf_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check("vec_waddr", 32'(rf_waddr), 32'(vecs[i].wreg));
                check("vec_wdata", rf_wdata, vecs[i].res);
            end
            check("vec_stall", 32'(stall), 32'd0);
            check("vec_cur_pc", cur_pc, vecs[i].pc);
            tick();
            exp_ret = exp_ret + CW'(vecs[i].cnt);
            check("vec_retired", 32'(retired), 32'(exp_ret));
        end
        idle_inputs();

        dmem.ack = 1'b1;
        mid();
        check("stray_ack_req", 32'(dmem.req), 32'd0);
        tick();
        dmem.ack = 1'b0;
        mid();
        check("stray_ack_req2", 32'(dmem.req), 32'd0);
        check("stray_ack_stall", 32'(stall), 32'd0);
        tick();

        mem_op(OP_LW, 5'd7,  32'h40, 32'h0,    32'h200, 1, 32'hCAFEF00D, 1, 1'b0, 1'b1, 32'hCAFEF00D);
        mem_op(OP_SW, 5'd8,  32'h80, 32'h55AA, 32'h204, 5, 32'h0,        5, 1'b0, 1'b0, 32'h0);
        mem_op(OP_LW, 5'd6,  32'hC0, 32'h0,    32'h208, 8, 32'h12345678, 8, 1'b0, 1'b1, 32'h12345678);
        mem_op(OP_LW, 5'd10, 32'hC4, 32'h0,    32'h20C, 0, 32'h0,        8, 1'b1, 1'b1, 32'h0);
        mem_op(OP_LW, 5'd0,  32'hC8, 32'h0,    32'h210, 2, 32'hFEEDFACE, 2, 1'b0, 1'b0, 32'h0);

        op_in = OP_LW; wreg_in = 5'd11; result_in = 32'hD0; pc_in = 32'h300;
        tick();
        op_in = OP_NOP;
        mid();
        check("rstmid_req1", 32'(dmem.req), 32'd1);
        tick();
        rst = 1'b1;
        mid();
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_rf_we", 32'(rf_we), 32'd0);
        tick();
        rst = 1'b0;
        exp_ret = '0;
        exp_err = 1'b0;
        mid();
        check("rstmid_req", 32'(dmem.req), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        check("rstmid_retired", 32'(retired), 32'd0);
        check("rstmid_rf_we2", 32'(rf_we), 32'd0);
        tick();
        op_in = 6'd0; wreg_in = 5'd12; result_in = 32'h42;
        mid();
        check("post_rst_idle_we", 32'(rf_we), 32'd1);
        tick();
        exp_ret = exp_ret + CW'(1);
        check("post_rst_retired", 32'(retired), 32'(exp_ret));

        for (int i = 0; i < 14; i++) tick();
        check("retired_all_ones", 32'(retired), 32'hF);
        tick();
        check("retired_wrap", 32'(retired), 32'h0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
